umem_arbiter: RTL and testbench

//  Shares the single-port unified byte-addressed memory (umem) between the instruction-fetch

---
 rtl/umem_arbiter_if.sv | 46 ++++
 rtl/umem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_umem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/umem_arbiter_if.sv
// +------------------------------------------------------------------+
// | umem_arbiter_if : request/response and umem bus bundle           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface umem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [2:0]    d_funct3;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic [AW-1:0] mem_addr;
  logic          mem_rw;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_addr, mem_rw, mem_wdata, mem_funct3
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_addr, mem_rw, mem_wdata, mem_funct3
  );
endinterface

`default_nettype wire

// File: rtl/umem_arbiter.sv
// +------------------------------------------------------------------+
// | umem_arbiter : IF / load-store arbiter for the single-port umem   |
// | Optional macro ALIGN_CHECK_EN: misaligned D accesses -> d_err     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module umem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  umem_arbiter_if.slave bus
);

  localparam int c_sw = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_MAX);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_resp   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [c_sw-1:0] starve_q, starve_d;

  logic          w_arb;
  logic          w_force_if;
  logic          w_grant_d;
  logic          w_grant_if;
  logic          w_misaligned;
  logic [2:0]    w_store_f3;
  logic [DW-1:0] w_ext;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rw_q, mem_rw_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]    mem_funct3_q, mem_funct3_d;

  logic          owner_q, owner_d;     // 1 = D owns the transaction
  logic          we_q, we_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic          err_q, err_d;

  logic          if_rvalid_q, if_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

`ifdef ALIGN_CHECK_EN
  logic d_err_q, d_err_d;

  assign w_misaligned = ((bus.d_funct3[1:0] == 2'b01) && bus.d_addr[0]) ||
                        ((bus.d_funct3[1:0] == 2'b10) && (bus.d_addr[1:0] != 2'b00));
  assign d_err_d      = d_rvalid_d && err_q;
  assign bus.d_err    = d_err_q;

  always_ff @(posedge clk) begin
    if (rst) d_err_q <= 1'b0;
    else     d_err_q <= d_err_d;
  end
`else
  assign w_misaligned = 1'b0;
  assign bus.d_err    = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= c_idle;
    else     state_q <= state_d;
  end

  // ---------------- FSM: arbitration and next state ----------------
  always_comb begin
    w_arb      = !rst && ((state_q == c_idle) || (state_q == c_resp));
    w_force_if = bus.if_req && (starve_q == c_starve_max);
    w_grant_d  = w_arb && bus.d_req && !w_force_if;
    w_grant_if = w_arb && bus.if_req && !w_grant_d;

    state_d = state_q;
    case (state_q)
      c_idle, c_resp: state_d = (w_grant_d || w_grant_if) ? c_access : c_idle;
      c_access:       state_d = c_resp;
      default:        state_d = c_idle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.if_gnt = w_grant_if;
    bus.d_gnt  = w_grant_d;
  end

  // Starvation counter only advances while a fetch is actually waiting
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || w_grant_if)
      starve_d = '0;
    else if (w_grant_d && (starve_q != c_starve_max))
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    w_store_f3 = ((bus.d_funct3 == 3'b000) || (bus.d_funct3 == 3'b001)) ?
                 bus.d_funct3 : 3'b010;

    w_ext = bus.mem_rdata;
    case (ld_f3_q)
      3'b000:  w_ext = {{(DW-8){bus.mem_rdata[7]}},   bus.mem_rdata[7:0]};
      3'b001:  w_ext = {{(DW-16){bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b100:  w_ext = {{(DW-8){1'b0}},               bus.mem_rdata[7:0]};
      3'b101:  w_ext = {{(DW-16){1'b0}},              bus.mem_rdata[15:0]};
      default: w_ext = bus.mem_rdata;
    endcase
  end

  // mem_* flops hold a value only during ACCESS; every other cycle they load zero
  always_comb begin
    mem_addr_d   = '0;
    mem_rw_d     = 1'b0;
    mem_wdata_d  = '0;
    mem_funct3_d = '0;
    owner_d      = owner_q;
    we_d         = we_q;
    ld_f3_d      = ld_f3_q;
    err_d        = err_q;

    if (w_grant_d) begin
      mem_addr_d   = bus.d_addr;
      mem_rw_d     = bus.d_we && !w_misaligned;
      mem_wdata_d  = bus.d_wdata;
      mem_funct3_d = w_store_f3;
      owner_d      = 1'b1;
      we_d         = bus.d_we;
      ld_f3_d      = bus.d_funct3;
      err_d        = w_misaligned;
    end else if (w_grant_if) begin
      mem_addr_d   = bus.if_addr;
      mem_funct3_d = 3'b010;
      owner_d      = 1'b0;
      we_d         = 1'b0;
      ld_f3_d      = 3'b010;
      err_d        = 1'b0;
    end

    if_rvalid_d = (state_q == c_access) && !owner_q;
    d_rvalid_d  = (state_q == c_access) && owner_q;
    if_rdata_d  = if_rvalid_d ? bus.mem_rdata : '0;
    d_rdata_d   = (d_rvalid_d && !we_q && !err_q) ? w_ext : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      mem_addr_q   <= '0;
      mem_rw_q     <= 1'b0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      ld_f3_q      <= '0;
      err_q        <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      starve_q     <= starve_d;
      mem_addr_q   <= mem_addr_d;
      mem_rw_q     <= mem_rw_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      ld_f3_q      <= ld_f3_d;
      err_q        <= err_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_funct3 = mem_funct3_q;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rvalid   = d_rvalid_q;
  assign bus.d_rdata    = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_umem_arbiter.sv
// +------------------------------------------------------------------+
// | tb_umem_arbiter : directed scoreboard bench for umem_arbiter      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_umem_arbiter;
  localparam int AW         = 8;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  umem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  umem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // byte-addressed umem model with wrapping combinational read
  logic [7:0] umem [256];
  logic [7:0] a1, a2, a3;
  assign a1 = bus.mem_addr + 8'd1;
  assign a2 = bus.mem_addr + 8'd2;
  assign a3 = bus.mem_addr + 8'd3;
  assign bus.mem_rdata = {umem[a3], umem[a2], umem[a1], umem[bus.mem_addr]};

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) umem[i] <= 8'h00;
      umem[8'h02] <= 8'hAA; umem[8'h03] <= 8'hBB; umem[8'h04] <= 8'hCC; umem[8'h05] <= 8'hDD;
      umem[8'h10] <= 8'hEF; umem[8'h11] <= 8'hBE; umem[8'h12] <= 8'hAD; umem[8'h13] <= 8'hDE;
      umem[8'h20] <= 8'h00; umem[8'h21] <= 8'h80;
      umem[8'h30] <= 8'h44; umem[8'h31] <= 8'h33; umem[8'h32] <= 8'h22; umem[8'h33] <= 8'h11;
    end else if (bus.mem_rw) begin
      umem[bus.mem_addr] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3 != 3'b000) umem[a1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3 == 3'b010) begin
        umem[a2] <= bus.mem_wdata[23:16];
        umem[a3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // scoreboard: {err, rdata}
  logic [32:0] if_sb [$];
  logic [32:0] d_sb  [$];

  logic [7:0]  cur_if_addr, cur_d_addr;
  logic [31:0] cur_if_exp;
  logic [32:0] cur_d_exp;
  logic        cur_d_rw, cur_d_f3_chk;
  logic [2:0]  cur_d_f3;

  logic        g_if, g_d, mem_chk, e_rw, e_f3_chk;
  logic [7:0]  e_addr;
  logic [2:0]  e_f3;
  int          rw_cycles = 0;
  int          n_gnt     = 0;
  logic        order     [10];
  logic        exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Samples grants with this cycle's inputs, crosses one rising edge, then checks outputs.
  task automatic tick();
    logic [32:0] e;
    #1;
    g_if = bus.if_gnt;
    g_d  = bus.d_gnt;
    if (g_if && g_d) chk("gnt_exclusive", 32'd1, 32'd0);
    if (g_d) begin
      d_sb.push_back(cur_d_exp);
      mem_chk = 1'b1; e_addr = cur_d_addr; e_rw = cur_d_rw; e_f3 = cur_d_f3; e_f3_chk = cur_d_f3_chk;
    end else if (g_if) begin
      if_sb.push_back({1'b0, cur_if_exp});
      mem_chk = 1'b1; e_addr = cur_if_addr; e_rw = 1'b0; e_f3 = 3'b010; e_f3_chk = 1'b1;
    end
    if ((g_if || g_d) && n_gnt < 10) begin
      order[n_gnt] = g_d;
      n_gnt++;
    end
    @(posedge clk);
    #1;
    if (bus.mem_rw) rw_cycles++;
    if (mem_chk) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("mem_rw", 32'(bus.mem_rw), 32'(e_rw));
      if (e_f3_chk) chk("mem_funct3", 32'(bus.mem_funct3), 32'(e_f3));
      mem_chk = 1'b0;
    end
    if (bus.if_rvalid) begin
      if (if_sb.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = if_sb.pop_front();
        chk("if_rdata", bus.if_rdata, e[31:0]);
      end
    end
    if (bus.d_rvalid) begin
      if (d_sb.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = d_sb.pop_front();
        chk("d_rdata", bus.d_rdata, e[31:0]);
        chk("d_err", 32'(bus.d_err), 32'(e[32]));
      end
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_if_gnt"},     32'(bus.if_gnt),     32'd0);
    chk({nm, "_d_gnt"},      32'(bus.d_gnt),      32'd0);
    chk({nm, "_if_rvalid"},  32'(bus.if_rvalid),  32'd0);
    chk({nm, "_d_rvalid"},   32'(bus.d_rvalid),   32'd0);
    chk({nm, "_if_rdata"},   bus.if_rdata,        32'd0);
    chk({nm, "_d_rdata"},    bus.d_rdata,         32'd0);
    chk({nm, "_d_err"},      32'(bus.d_err),      32'd0);
    chk({nm, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    chk({nm, "_mem_rw"},     32'(bus.mem_rw),     32'd0);
    chk({nm, "_mem_wdata"},  bus.mem_wdata,       32'd0);
    chk({nm, "_mem_funct3"}, 32'(bus.mem_funct3), 32'd0);
  endtask

  task automatic if_op(input string nm, input logic [7:0] addr, input logic [31:0] exp);
    cur_if_addr = addr; cur_if_exp = exp;
    bus.if_addr = addr; bus.if_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (g_if) break;
    end
    chk({nm, "_gnt"}, 32'(g_if), 32'd1);
    bus.if_req = 1'b0;
    tick();
    chk({nm, "_rvalid_t2"}, 32'(bus.if_rvalid), 32'd1);
    tick();
    chk({nm, "_sb_empty"}, 32'(if_sb.size()), 32'd0);
  endtask

  task automatic d_op(input string nm, input logic we, input logic [2:0] f3, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input logic exp_rw, input logic f3_chk, input logic [2:0] exp_f3);
    int rw0;
    rw0 = rw_cycles;
    cur_d_addr = addr; cur_d_exp = {exp_err, exp_rd}; cur_d_rw = exp_rw;
    cur_d_f3_chk = f3_chk; cur_d_f3 = exp_f3;
    bus.d_we = we; bus.d_funct3 = f3; bus.d_addr = addr; bus.d_wdata = wd; bus.d_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (g_d) break;
    end
    chk({nm, "_gnt"}, 32'(g_d), 32'd1);
    bus.d_req = 1'b0;
    tick();
    chk({nm, "_rvalid_t2"}, 32'(bus.d_rvalid), 32'd1);
    tick();
    chk({nm, "_sb_empty"}, 32'(d_sb.size()), 32'd0);
    chk({nm, "_rw_cycles"}, 32'(rw_cycles - rw0), 32'(exp_rw));
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_funct3 = '0; bus.d_addr = '0; bus.d_wdata = '0;
    mem_chk = 1'b0; e_rw = 1'b0; e_f3_chk = 1'b0; e_addr = '0; e_f3 = '0;
    cur_if_addr = '0; cur_if_exp = '0; cur_d_addr = '0; cur_d_exp = '0;
    cur_d_rw = 1'b0; cur_d_f3_chk = 1'b0; cur_d_f3 = '0;
    rst = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    if_op("fetch10", 8'h10, 32'hDEADBEEF);
    d_op("lb21",  1'b0, 3'b000, 8'h21, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 3'b000);
    d_op("lbu21", 1'b0, 3'b100, 8'h21, 32'h0, 32'h00000080, 1'b0, 1'b0, 1'b0, 3'b000);
    d_op("lh20",  1'b0, 3'b001, 8'h20, 32'h0, 32'hFFFF8000, 1'b0, 1'b0, 1'b0, 3'b000);
    d_op("sh30",  1'b1, 3'b001, 8'h30, 32'h1234ABCD, 32'h0, 1'b0, 1'b1, 1'b1, 3'b001);
    d_op("lw30",  1'b0, 3'b010, 8'h30, 32'h0, 32'h1122ABCD, 1'b0, 1'b0, 1'b0, 3'b000);
    d_op("s111",  1'b1, 3'b111, 8'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b1, 3'b010);
    d_op("lw40",  1'b0, 3'b010, 8'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 3'b000);

    // Both requesters held: expect D D D D I D D D D I
    n_gnt = 0;
    cur_if_addr = 8'h10; cur_if_exp = 32'hDEADBEEF; bus.if_addr = 8'h10;
    cur_d_addr = 8'h10; cur_d_exp = {1'b0, 32'hDEADBEEF}; cur_d_rw = 1'b0; cur_d_f3_chk = 1'b0;
    bus.d_we = 1'b0; bus.d_funct3 = 3'b010; bus.d_addr = 8'h10;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    for (int i = 0; i < 60 && n_gnt < 10; i++) tick();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("contention_grants", 32'(n_gnt), 32'd10);
    tick();
    tick();
    for (int i = 0; i < 10; i++) chk($sformatf("order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
    chk("contention_if_sb_empty", 32'(if_sb.size()), 32'd0);
    chk("contention_d_sb_empty", 32'(d_sb.size()), 32'd0);

    // Reset while a fetch is in ACCESS: dropped, no rvalid
    cur_if_addr = 8'h10; cur_if_exp = 32'hDEADBEEF; bus.if_addr = 8'h10; bus.if_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (g_if) break;
    end
    chk("rst_pre_gnt", 32'(g_if), 32'd1);
    rst = 1'b1;
    if_sb.delete();
    tick();
    check_outputs_zero("rst_mid");
    rst = 1'b0;
    tick();
    chk("gnt_after_rst", 32'(g_if), 32'd1);
    bus.if_req = 1'b0;
    tick();
    chk("rvalid_after_rst", 32'(bus.if_rvalid), 32'd1);
    tick();
    chk("rst_sb_empty", 32'(if_sb.size()), 32'd0);

    d_op("lw02", 1'b0, 3'b010, 8'h02, 32'h0, ALIGN_ON ? 32'h0 : 32'hDDCCBBAA, ALIGN_ON,
         1'b0, 1'b0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
